// File: rtl/bridge_gate_drv_pkg.sv
// Shared types and timing helpers for the bridge gate-drive path.
package bridge_gate_drv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ON_A  = 3'd1,
    ON_B  = 3'd2,
    DEAD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  // Nanoseconds to clock cycles, rounded up so a minimum time is never shortened.
  function automatic int ns2cyc(input int ns, input int clk_mhz);
    return (ns * clk_mhz + 999) / 1000;
  endfunction

endpackage

// File: rtl/bridge_dead_cnt.sv
// Loadable down-counter that stops at zero; used as the dead-time timer.
module bridge_dead_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_cnt <= '0;
    else if (i_load)         r_cnt <= i_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bridge_gate_drv.sv
// Full-bridge gate drive: dead-time insertion between diagonal pairs,
// overlap and conduction-watchdog fault latch.
module bridge_gate_drv
  import bridge_gate_drv_pkg::*;
#(
  parameter int CLK_MHZ   = 100,
  parameter int DEAD_NS   = 100,
  parameter int MAX_ON_NS = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_p,
  input  logic in_n,
  input  logic fault_clr,
  output logic gate_a,
  output logic gate_b,
  output logic fault
);

  localparam int DEAD_CYC   = ns2cyc(DEAD_NS, CLK_MHZ);
  localparam int MAX_ON_CYC = ns2cyc(MAX_ON_NS, CLK_MHZ);
  localparam int ON_W       = $clog2(MAX_ON_CYC + 1);
  localparam int DW         = $clog2(DEAD_CYC + 1);

  generate
    if (DEAD_CYC < 1) begin : g_bad_dead
      $error("bridge_gate_drv: DEAD_CYC must be at least 1");
    end
    if (MAX_ON_CYC <= DEAD_CYC) begin : g_bad_max_on
      $error("bridge_gate_drv: MAX_ON_CYC must exceed DEAD_CYC");
    end
  endgenerate

  logic            r_req_p, r_req_n;
  state_t          r_state, w_nxt;
  logic [ON_W-1:0] r_on_cnt;
  logic            w_dead_load, w_dead_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_p <= 1'b0;
      r_req_n <= 1'b0;
    end else begin
      r_req_p <= in_p;
      r_req_n <= in_n;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (r_req_p && !r_req_n)      w_nxt = ON_A;
        else if (!r_req_p && r_req_n) w_nxt = ON_B;
      end
      ON_A: begin
        if (!r_req_p)                               w_nxt = DEAD;
        else if (r_on_cnt == ON_W'(MAX_ON_CYC))     w_nxt = FAULT;
      end
      ON_B: begin
        if (!r_req_n)                               w_nxt = DEAD;
        else if (r_on_cnt == ON_W'(MAX_ON_CYC))     w_nxt = FAULT;
      end
      DEAD: begin
        // Target is picked only when the timer expires, so late requests still wait it out.
        if (w_dead_zero) begin
          if (r_req_p)      w_nxt = ON_A;
          else if (r_req_n) w_nxt = ON_B;
          else              w_nxt = IDLE;
        end
      end
      FAULT: begin
        if (fault_clr && !r_req_p && !r_req_n) w_nxt = DEAD;
      end
      default: w_nxt = IDLE;
    endcase
    // Shoot-through request beats every other transition, watchdog included.
    if (r_req_p && r_req_n) w_nxt = FAULT;
  end

  assign w_dead_load = (w_nxt == DEAD) && (r_state != DEAD);

  bridge_dead_cnt #(.W(DW)) u_dead_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_dead_load),
    .i_val  (DW'(DEAD_CYC - 1)),
    .o_zero (w_dead_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_on_cnt <= '0;
      gate_a   <= 1'b0;
      gate_b   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt == ON_A || w_nxt == ON_B)
        r_on_cnt <= (w_nxt == r_state) ? r_on_cnt + 1'b1 : ON_W'(1);
      else
        r_on_cnt <= '0;
      gate_a <= (w_nxt == ON_A);
      gate_b <= (w_nxt == ON_B);
      fault  <= (w_nxt == FAULT);
    end
  end

endmodule

// File: doc/bridge_gate_drv.md
# bridge_gate_drv

Full-bridge gate-drive stage between the interrupter and the gate-driver pins. It converts the complementary phase requests `out_p` / `out_n` into two diagonal-pair gate signals. It guarantees a programmable dead time between pairs, and latches a fault on an overlapping request or on an over-long conduction (lost feedback). Gates stay off until the fault is cleared.

## Interface
- `CLK_MHZ`, 100: clock frequency in MHz.
- `DEAD_NS`, 100: minimum both-off time in ns. `DEAD_CYC = ceil(DEAD_NS*CLK_MHZ/1000)`. Must be ≥ 1; elaboration error otherwise.
- `MAX_ON_NS`, 5_000: maximum continuous conduction of one pair in ns. `MAX_ON_CYC = ceil(MAX_ON_NS*CLK_MHZ/1000)`. Must be > `DEAD_CYC`.

- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `in_p`, in, 1: request for pair A (interrupter `out_p`).
- `in_n`, in, 1: request for pair B (interrupter `out_n`).
- `fault_clr`, in, 1: level; releases a latched fault.
- `gate_a`, out, 1: pair A gate command, registered.
- `gate_b`, out, 1: pair B gate command, registered.
- `fault`, out, 1: latched fault flag, registered.

## Operation
- Input stage: `in_p` / `in_n` are registered once into `req_p` / `req_n`. The FSM acts only on the registered copies.
- FSM states: `IDLE`, `ON_A`, `ON_B`, `DEAD`, `FAULT`. Outputs are decoded from the next state and registered:
  - `gate_a` = `ON_A`
  - `gate_b` = `ON_B`
  - `fault` = `FAULT`
- `IDLE`:
  - `req_p && !req_n` → `ON_A`.
  - `!req_p && req_n` → `ON_B`.
  - Neither request → stay.
- `ON_A`:
  - On entry, `on_cnt` loads 1 and increments each cycle in the state.
  - `!req_p` → `DEAD`.
  - `req_p` with `on_cnt == MAX_ON_CYC` → `FAULT`.
- `ON_B`: symmetric to `ON_A`, using `req_n`.
- `DEAD`:
  - On entry, `dead_cnt` loads `DEAD_CYC-1` and decrements to 0.
  - At 0, the target is re-evaluated from the current requests: A → `ON_A`, B → `ON_B`, none → `IDLE`.
  - A request change during `DEAD` never shortens it.
- Overlap: `req_p && req_n` in any non-`FAULT` state → `FAULT`. This has priority over every other transition, including the watchdog.
- `FAULT`:
  - Both gates are 0.
  - Leaves only when `fault_clr && !req_p && !req_n`; it then goes to `DEAD` (full dead time), never straight to `ON`.
  - `fault_clr` with any request active is ignored.
- Direct `ON_A` ↔ `ON_B` transitions are forbidden. `gate_a && gate_b` is never 1.
- Reset (any time, including mid-pulse): state `IDLE`; `gate_a`, `gate_b`, `fault`, `req_*` and counters all go to 0 immediately. After release, no gate asserts before a request is sampled.

## Timing
- Request assertion from `IDLE`: `in_p` sampled high at edge k → `gate_a` high after edge k+1 (2-cycle latency).
- Release: `in_p` sampled low at edge k → `gate_a` low after edge k+1.
- Dead time: after a gate falls, the opposite gate rises no earlier than `DEAD_CYC` cycles later. It rises exactly `DEAD_CYC` cycles later when the opposite request is already present.
- Complementary swap (`in_p` falls and `in_n` rises on the same edge): `gate_b` rises exactly `DEAD_CYC` cycles after `gate_a` falls.
- Watchdog: `gate_a` stays high for at most `MAX_ON_CYC` cycles. `fault` rises on the same edge that `gate_a` falls.
- Overlap: `fault` rises 2 cycles after the overlapping inputs are sampled. Gates fall on that same edge.
- Counter widths: `$clog2(MAX_ON_CYC+1)` for `on_cnt` and `$clog2(DEAD_CYC+1)` for `dead_cnt`. Neither counter wraps: `on_cnt` saturates via the `FAULT` transition, `dead_cnt` stops at 0.

## Structure
- Package `bridge_gate_drv_pkg` holds:
  - the state enum;
  - function `ns2cyc(ns, clk_mhz)` (ceil division), shared with other timing blocks.
- One sub-module, `bridge_dead_cnt`: a loadable down-counter with a `zero` flag, instantiated for the dead timer. The watchdog counter stays inline.
- Top level holds the input registers, FSM and output registers only.

## Test plan
(`CLK_MHZ`=100, `DEAD_NS`=100 → `DEAD_CYC`=10; `MAX_ON_NS`=5000 → `MAX_ON_CYC`=500.)
- Reset, then `in_p` high for 50 cycles → `gate_a` high 2 cycles after the rise, for 50 cycles; `gate_b` and `fault` stay 0.
- Complementary square wave, 200-cycle half-period, swapped on the same edge → after each gate falls, the other rises exactly 10 cycles later; never both 1.
- `in_n` rises 3 cycles after `in_p` falls → `gate_b` still rises 10 cycles after `gate_a` fell.
- `in_p` held 600 cycles → `gate_a` high exactly 500 cycles, then `fault`=1. `fault_clr` is ignored while `in_p` is high. After `in_p` drops, `fault_clr` pulse → 10-cycle `DEAD`, then `IDLE`.
- `in_p` and `in_n` high together for 1 cycle during `ON_A` → `fault`=1 two cycles later; `gate_a` falls on the same edge.
- `rst_n` asserted mid-`ON_B` → `gate_b` low immediately (asynchronous). After release with `in_n` still high → `gate_b` high 2 cycles after the first sampling edge.
